// File: rtl/voice_alloc_pkg.sv
// voice_alloc_pkg: shared types and widths for the voice allocator
package voice_alloc_pkg;
    localparam int NOTE_W = 7;
    localparam int VEL_W = 7;
    typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;
    typedef enum logic {NOTE_ON, NOTE_OFF} ev_kind_t;
    typedef struct packed {
        ev_kind_t kind;
        logic [NOTE_W-1:0] note;
        logic [VEL_W-1:0] vel;
    } event_t;
    function automatic event_t classify(input logic released, input logic [NOTE_W-1:0] note,
                                        input logic [VEL_W-1:0] vel);
        event_t e;
        e.kind = (released || vel == '0) ? NOTE_OFF : NOTE_ON;
        e.note = note;
        e.vel = vel;
        return e;
    endfunction
endpackage

// File: rtl/voice_alloc_if.sv
// voice_alloc_if: note event inputs and per-voice outputs of the allocator
interface voice_alloc_if #(parameter int NUM_VOICES = 4);
    import voice_alloc_pkg::*;
    logic note_pressed;
    logic note_released;
    logic [NOTE_W-1:0] note_interface;
    logic [VEL_W-1:0] velocity;
    logic [NUM_VOICES-1:0] voice_gate;
    logic [NOTE_W*NUM_VOICES-1:0] voice_note;
    logic [VEL_W*NUM_VOICES-1:0] voice_velocity;
    logic [NUM_VOICES-1:0] voice_trig;
    logic busy;
    logic dropped;
    modport master (
        output note_pressed, note_released, note_interface, velocity,
        input voice_gate, voice_note, voice_velocity, voice_trig, busy, dropped
    );
    modport slave (
        input note_pressed, note_released, note_interface, velocity,
        output voice_gate, voice_note, voice_velocity, voice_trig, busy, dropped
    );
endinterface

// File: rtl/voice_slot.sv
// voice_slot: one voice's gate, note, velocity and saturating age registers
module voice_slot
    import voice_alloc_pkg::*;
#(
    parameter int AGE_W = 8
) (
    input logic clk32,
    input logic rst,
    input logic load,
    input logic rel,
    input logic tick,
    input logic [NOTE_W-1:0] note_in,
    input logic [VEL_W-1:0] vel_in,
    output logic gate,
    output logic [NOTE_W-1:0] note,
    output logic [VEL_W-1:0] vel,
    output logic [AGE_W-1:0] age
);
    always_ff @(posedge clk32) begin
        if (rst) begin
            gate <= 1'b0;
            note <= '0;
            vel <= '0;
            age <= '0;
        end else begin
            if (load) begin
                gate <= 1'b1;
                note <= note_in;
                vel <= vel_in;
                age <= '0;
            end else if (tick && age != '1) begin
                age <= age + 1'b1;
            end
            if (rel) gate <= 1'b0;
        end
    end
endmodule

// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic voice allocator; define VOICE_ALLOC_STEAL_EN to steal the oldest voice when full
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W = 8
) (
    input logic clk32,
    input logic rst,
    voice_alloc_if.slave bus
);
    localparam int IW = $clog2(NUM_VOICES);
    state_t state;
    event_t ev, pend, in_ev;
    logic pend_v, pulse, is_on, is_apply, assign_ok;
    logic [IW-1:0] idx, match_i, free_i, old_i, target;
    logic match_f, free_f;
    logic [AGE_W-1:0] old_age;
    logic [NUM_VOICES-1:0] gate_q, load, rel, tick;
    logic [NOTE_W-1:0] note_q [NUM_VOICES];
    logic [VEL_W-1:0] vel_q [NUM_VOICES];
    logic [AGE_W-1:0] age_q [NUM_VOICES];
    logic [NOTE_W*NUM_VOICES-1:0] note_pk;
    logic [VEL_W*NUM_VOICES-1:0] vel_pk;
    always_comb begin
        pulse = bus.note_pressed | bus.note_released;
        in_ev = classify(bus.note_released, bus.note_interface, bus.velocity);
        is_on = ev.kind == NOTE_ON;
        is_apply = state == APPLY;
        target = match_f ? match_i : free_f ? free_i : old_i;
`ifdef VOICE_ALLOC_STEAL_EN
        assign_ok = is_on;
`else
        assign_ok = is_on && (match_f || free_f);
`endif
    end
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
        assign load[i] = is_apply && assign_ok && target == IW'(i);
        assign tick[i] = is_apply && assign_ok && target != IW'(i);
        assign rel[i] = is_apply && !is_on && match_f && match_i == IW'(i);
        assign note_pk[NOTE_W*i +: NOTE_W] = note_q[i];
        assign vel_pk[VEL_W*i +: VEL_W] = vel_q[i];
        voice_slot #(.AGE_W(AGE_W)) u_slot (
            .clk32(clk32),
            .rst(rst),
            .load(load[i]),
            .rel(rel[i]),
            .tick(tick[i]),
            .note_in(ev.note),
            .vel_in(ev.vel),
            .gate(gate_q[i]),
            .note(note_q[i]),
            .vel(vel_q[i]),
            .age(age_q[i])
        );
    end
    assign bus.voice_gate = gate_q;
    assign bus.voice_note = note_pk;
    assign bus.voice_velocity = vel_pk;
    always_ff @(posedge clk32) begin
        if (rst) begin
            state <= IDLE;
            ev <= '0;
            pend <= '0;
            pend_v <= 1'b0;
            idx <= '0;
            match_i <= '0;
            free_i <= '0;
            old_i <= '0;
            match_f <= 1'b0;
            free_f <= 1'b0;
            old_age <= '0;
            bus.voice_trig <= '0;
            bus.busy <= 1'b0;
            bus.dropped <= 1'b0;
        end else begin
            bus.voice_trig <= load;
            bus.dropped <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_v || pulse) begin
                        ev <= pend_v ? pend : in_ev;
                        state <= SCAN;
                        bus.busy <= 1'b1;
                        idx <= '0;
                        match_f <= 1'b0;
                        free_f <= 1'b0;
                    end
                    // a fresh pulse refills pending as the old entry leaves it
                    if (pend_v) begin
                        pend_v <= pulse;
                        pend <= in_ev;
                    end
                end
                SCAN: begin
                    if (gate_q[idx] && note_q[idx] == ev.note && !match_f) begin
                        match_f <= 1'b1;
                        match_i <= idx;
                    end
                    if (!gate_q[idx] && !free_f) begin
                        free_f <= 1'b1;
                        free_i <= idx;
                    end
                    if (idx == '0 || age_q[idx] > old_age) begin
                        old_i <= idx;
                        old_age <= age_q[idx];
                    end
                    idx <= idx + 1'b1;
                    if (idx == IW'(NUM_VOICES - 1)) state <= APPLY;
                end
                default: begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                    bus.dropped <= is_on && !assign_ok;
                end
            endcase
            if (state != IDLE && pulse) begin
                if (pend_v) begin
                    bus.dropped <= 1'b1;
                end else begin
                    pend <= in_ev;
                    pend_v <= 1'b1;
                end
            end
        end
    end
endmodule
